// File: rtl/step_pulse_gen_pkg.sv
// Shared motor-control definitions: step FSM encoding, default step timing
// and the tracking-mode set used by the motion front end.
package step_pulse_gen_pkg;

  // Default timing at 50 MHz: 2 us step high time, 5 us direction setup.
  localparam int PULSE_W_DEF   = 100;
  localparam int DIR_SETUP_DEF = 250;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIR_WAIT = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_LOW      = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    DIR_WAIT = ST_DIR_WAIT,
    HIGH     = ST_HIGH,
    LOW      = ST_LOW
  } step_state_e;

  typedef enum logic [1:0] {
    TRACK_OFF      = 2'd0,
    TRACK_VELOCITY = 2'd1,
    TRACK_POSITION = 2'd2
  } track_mode_e;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Command/status bundle between a motion controller and the step generator.
interface step_pulse_gen_if #(
  parameter int WIDTH_WORK = 16,
  parameter int POS_W      = 32
);

  logic                  enable;
  logic [WIDTH_WORK-1:0] period_in;
  logic                  period_load;
  logic                  dir_in;
  logic                  pos_clear;
  logic                  step_out;
  logic                  dir_out;
  logic [POS_W-1:0]      position;
  logic                  busy;

  modport master (
    output enable, period_in, period_load, dir_in, pos_clear,
    input  step_out, dir_out, position, busy
  );

  modport slave (
    input  enable, period_in, period_load, dir_in, pos_clear,
    output step_out, dir_out, position, busy
  );

endinterface

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper driver: fixed-width step
// pulses at a programmable period, direction setup gap, signed position count.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int WIDTH_WORK = 16,
  parameter int PULSE_W    = PULSE_W_DEF,
  parameter int DIR_SETUP  = DIR_SETUP_DEF,
  parameter int POS_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  step_pulse_gen_if.slave    bus
);

  localparam logic [WIDTH_WORK-1:0] CNT_ONE  = WIDTH_WORK'(1);
  localparam logic [WIDTH_WORK-1:0] PULSE_LD = WIDTH_WORK'(PULSE_W - 1);
  localparam logic [WIDTH_WORK-1:0] DIR_LD   = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] MIN_PER  = WIDTH_WORK'(2 * PULSE_W);
  localparam logic [WIDTH_WORK-1:0] LOW_OFS  = WIDTH_WORK'(PULSE_W + 1);
  localparam logic [POS_W-1:0]      POS_ONE  = POS_W'(1);

  step_state_e           state_q, state_d;
  logic [WIDTH_WORK-1:0] cnt_q, cnt_d;
  logic [WIDTH_WORK-1:0] period_q;
  logic [WIDTH_WORK-1:0] act_per_q, act_per_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic [POS_W-1:0]      pos_q, pos_d;

  logic                  can_run;
  logic                  enter_high;
  logic [WIDTH_WORK-1:0] eff_per;
  logic [WIDTH_WORK-1:0] low_cnt;

  assign can_run = bus.enable && (period_q != '0);

  // Short periods are stretched so the low time never drops below the pulse width.
  assign eff_per = (act_per_q < MIN_PER) ? MIN_PER : act_per_q;
  assign low_cnt = eff_per - LOW_OFS;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    dir_d      = dir_q;
    act_per_d  = act_per_q;
    enter_high = 1'b0;

    unique case (state_q)
      IDLE: begin
        step_d = 1'b0;
        if (can_run) begin
          if (bus.dir_in != dir_q) begin
            dir_d   = bus.dir_in;
            cnt_d   = DIR_LD;
            state_d = DIR_WAIT;
          end else begin
            enter_high = 1'b1;
          end
        end
      end

      DIR_WAIT: begin
        if (cnt_q == '0) begin
          if (can_run) enter_high = 1'b1;
          else         state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      HIGH: begin
        if (cnt_q == '0) begin
          step_d  = 1'b0;
          cnt_d   = low_cnt;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      LOW: begin
        if (cnt_q == '0) begin
          if (!can_run) begin
            state_d = IDLE;
          end else if (bus.dir_in != dir_q) begin
            // A reversal always passes through the setup gap before the next step.
            dir_d   = bus.dir_in;
            cnt_d   = DIR_LD;
            state_d = DIR_WAIT;
          end else begin
            enter_high = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The active period is sampled here only, so a reload never disturbs a step in flight.
    if (enter_high) begin
      state_d   = HIGH;
      step_d    = 1'b1;
      cnt_d     = PULSE_LD;
      act_per_d = period_q;
    end
  end

  always_comb begin
    pos_d = pos_q;
    if (bus.pos_clear)   pos_d = '0;
    else if (enter_high) pos_d = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      act_per_q <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_per_q <= act_per_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      if (bus.period_load) period_q <= bus.period_in;
    end
  end

  assign bus.step_out = step_q;
  assign bus.dir_out  = dir_q;
  assign bus.position = pos_q;
  assign bus.busy     = (state_q != IDLE);

  a_dir_stable_in_high : assert property (
    @(posedge clk) disable iff (rst) (state_q == HIGH) |=> $stable(dir_q)
  );

  a_step_only_in_high : assert property (
    @(posedge clk) disable iff (rst) step_q == (state_q == HIGH)
  );

endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized bench for step_pulse_gen: predicts step edge times, pulse widths,
// direction changes and position from period/direction arithmetic.
module tb_step_pulse_gen;

  localparam int WW  = 16;
  localparam int PW  = 4;
  localparam int DS  = 8;
  localparam int PSW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  step_pulse_gen_if #(.WIDTH_WORK(WW), .POS_W(PSW)) bus ();

  step_pulse_gen #(
    .WIDTH_WORK (WW),
    .PULSE_W    (PW),
    .DIR_SETUP  (DS),
    .POS_W      (PSW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, stamped with the cycle number at the negedge sample.
  int                     rise_q[$];
  logic signed [PSW-1:0]  rpos_q[$];
  int                     width_q[$];
  int                     dchg_q[$];
  int                     busy_fall = -1;
  logic                   step_prev = 1'b0;
  logic                   dir_prev  = 1'b0;
  logic                   busy_prev = 1'b0;
  int                     last_rise = 0;

  always @(negedge clk) begin
    if (bus.step_out === 1'b1 && step_prev === 1'b0) begin
      rise_q.push_back(cyc);
      rpos_q.push_back($signed(bus.position));
      last_rise = cyc;
    end
    if (bus.step_out === 1'b0 && step_prev === 1'b1) width_q.push_back(cyc - last_rise);
    if (bus.dir_out !== dir_prev) dchg_q.push_back(cyc);
    if (bus.busy === 1'b0 && busy_prev === 1'b1) busy_fall = cyc;
    step_prev = bus.step_out;
    dir_prev  = bus.dir_out;
    busy_prev = bus.busy;
  end

  // Model state carried between runs.
  logic signed [PSW-1:0] m_pos = '0;
  bit                    m_dir = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff(input int p);
    return (p < 2 * PW) ? 2 * PW : p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    rise_q.delete();
    rpos_q.delete();
    width_q.delete();
    dchg_q.delete();
    busy_fall = -1;
  endtask

  // One stepping run. rev_after: direction flips once that many steps were seen.
  // load_at/clear_at: strobe on the HIGH-entry edge of that step index (0 = none).
  task automatic run_steps(input string name, input int p1, input int p2, input bit d,
                           input int n, input int rev_after, input int load_at,
                           input int clear_at, input bit stop_zero);
    int                    exp_t[$];
    logic signed [PSW-1:0] exp_p[$];
    int                    exp_d[$];
    int                    per[$];
    int                    e, base, budget, busy_exp, per_i;
    bit                    dir_i, want, flipped, done;
    logic signed [PSW-1:0] pos;

    bus.period_in   = WW'(p1);
    bus.period_load = 1'b1;
    tick();
    bus.period_load = 1'b0;
    clear_obs();
    bus.dir_in = d;
    bus.enable = 1'b1;
    e = cyc;

    dir_i = m_dir;
    pos   = m_pos;
    for (int i = 0; i < n; i++) begin
      want  = (rev_after > 0 && i >= rev_after) ? !d : d;
      base  = (i == 0) ? e + 1 : exp_t[i-1] + eff(per[i-1]);
      if (want != dir_i) begin
        exp_d.push_back(base);
        base  = base + DS;
        dir_i = want;
      end
      per_i = (load_at > 0 && i > load_at) ? p2 : p1;
      per.push_back(per_i);
      exp_t.push_back(base);
      if (clear_at > 0 && i == clear_at) pos = '0;
      else                               pos = dir_i ? pos + 8'sd1 : pos - 8'sd1;
      exp_p.push_back(pos);
    end
    busy_exp = exp_t[n-1] + eff(per[n-1]);

    flipped = 1'b0;
    done    = 1'b0;
    budget  = busy_exp - e + 200;
    while (!done && budget > 0) begin
      bus.period_load = 1'b0;
      bus.pos_clear   = 1'b0;
      if (load_at > 0 && cyc == exp_t[load_at] - 1) begin
        bus.period_in   = WW'(p2);
        bus.period_load = 1'b1;
      end
      if (clear_at > 0 && cyc == exp_t[clear_at] - 1) bus.pos_clear = 1'b1;
      if (rev_after > 0 && !flipped && rise_q.size() >= rev_after) begin
        bus.dir_in = !d;
        flipped    = 1'b1;
      end
      if (rise_q.size() >= n) begin
        done = 1'b1;
        if (stop_zero) begin
          bus.period_in   = '0;
          bus.period_load = 1'b1;
        end else begin
          bus.enable = 1'b0;
        end
      end
      tick();
      budget--;
    end
    bus.period_load = 1'b0;
    bus.pos_clear   = 1'b0;
    if (!done) check({name, "_step_timeout"}, rise_q.size(), n);

    budget = 400;
    while (bus.busy !== 1'b0 && budget > 0) begin
      tick();
      budget--;
    end
    repeat (12) tick();

    check({name, "_rise_count"}, rise_q.size(), n);
    for (int i = 0; i < n && i < rise_q.size(); i++) begin
      check($sformatf("%s_rise%0d_cyc", name, i), rise_q[i], exp_t[i]);
      check($sformatf("%s_rise%0d_pos", name, i), rpos_q[i], exp_p[i]);
    end
    for (int i = 0; i < n && i < width_q.size(); i++)
      check($sformatf("%s_width%0d", name, i), width_q[i], PW);
    check({name, "_dir_changes"}, dchg_q.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < dchg_q.size(); i++)
      check($sformatf("%s_dirchg%0d_cyc", name, i), dchg_q[i], exp_d[i]);
    check({name, "_busy_fall"}, busy_fall, busy_exp);
    check({name, "_final_pos"}, $signed(bus.position), pos);
    check({name, "_final_dir"}, bus.dir_out, dir_i);
    check({name, "_idle_step"}, bus.step_out, 0);

    m_pos      = pos;
    m_dir      = dir_i;
    bus.enable = 1'b0;
    tick();
  endtask

  initial begin
    int p, n, ca;
    bit d;

    bus.enable      = 1'b0;
    bus.period_in   = '0;
    bus.period_load = 1'b0;
    bus.dir_in      = 1'b0;
    bus.pos_clear   = 1'b0;

    #1;
    check("rst_step_out", bus.step_out, 0);
    check("rst_dir_out", bus.dir_out, 0);
    check("rst_position", bus.position, 0);
    check("rst_busy", bus.busy, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Basic run: period 20, direction unchanged, stop by enable.
    run_steps("basic", 20, 0, 1'b0, 3, 0, 0, 0, 1'b0);
    // Reversal mid-run.
    run_steps("rev", 20, 0, m_dir, 4, 2, 0, 0, 1'b0);
    // Clamped period, stopped by loading zero.
    run_steps("clamp", 3, 0, m_dir, 3, 0, 0, 0, 1'b1);
    // Period reload landing on a HIGH-entry edge.
    run_steps("reload", $urandom_range(10, 30), $urandom_range(1, 30), m_dir, 4, 0, 1, 0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      p  = $urandom_range(1, 30);
      d  = 1'($urandom_range(0, 1));
      n  = $urandom_range(2, 4);
      ca = $urandom_range(0, n - 1);
      run_steps($sformatf("rnd%0d", k), p, 0, d, n, ($urandom_range(0, 2) == 0) ? 1 : 0,
                0, ca, 1'($urandom_range(0, 1)));
    end

    // Clear on a step edge, then count up through +127 into -128.
    run_steps("wrap", 8, 0, 1'b1, 130, 0, 0, 1, 1'b0);

    // Reset in the middle of a pulse.
    bus.period_in   = WW'(20);
    bus.period_load = 1'b1;
    tick();
    bus.period_load = 1'b0;
    clear_obs();
    bus.dir_in = 1'b1;
    bus.enable = 1'b1;
    for (int g = 0; g < 100 && rise_q.size() == 0; g++) tick();
    check("midrst_pre_step", bus.step_out, 1);
    check("midrst_pre_dir", bus.dir_out, 1);
    rst = 1'b1;
    #1;
    check("midrst_step_out", bus.step_out, 0);
    check("midrst_position", bus.position, 0);
    check("midrst_dir_out", bus.dir_out, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    clear_obs();
    repeat (60) tick();
    check("postrst_no_steps", rise_q.size(), 0);
    check("postrst_busy", bus.busy, 0);
    bus.enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
